// File: rtl/array_mult_sched.sv
// array_mult_sched: round-robin scheduler in front of the array_mult lane array.
// Two clients share one issue slot. A token pipe follows each vector through the
// multiplier and the rounding register, so each result returns to its issuer
// as a single-cycle pulse.
module array_mult_sched #(
  parameter int N        = 4,
  parameter int MULT_LAT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [N*36-1:0]   req0_dataa,
  input  logic [N*36-1:0]   req0_datab,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [N*36-1:0]   req1_dataa,
  input  logic [N*36-1:0]   req1_datab,
  output logic              mult_en,
  output logic [N*36-1:0]   mult_dataa,
  output logic [N*36-1:0]   mult_datab,
  input  logic [N*36-1:0]   mult_result,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic [N*36-1:0]   rsp0_result,
  output logic [N*36-1:0]   rsp1_result,
  output logic              busy
);

  logic                prio_q, prio_d;
  logic [MULT_LAT:1]   s_q, s_d;
  logic [MULT_LAT:1]   t_q, t_d;
  logic                r_q, rt_q;
  logic [N*36-1:0]     dataa_q, dataa_d;
  logic [N*36-1:0]     datab_q, datab_d;
  logic                grant0, grant1, issue, gntId;

  // Round-robin grant: a lone requester wins, a tie goes to prio; nothing while in reset.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (reset_n) begin
      if (req0_valid && (!req1_valid || !prio_q)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
    issue  = grant0 | grant1;
    gntId  = grant1;
    prio_d = issue ? ~gntId : prio_q;
  end

  // Operand mux: pass the winner straight through, otherwise keep the last operands.
  always_comb begin
    dataa_d = dataa_q;
    datab_d = datab_q;
    if (grant0) begin
      dataa_d = req0_dataa;
      datab_d = req0_datab;
    end else if (grant1) begin
      dataa_d = req1_dataa;
      datab_d = req1_datab;
    end
  end

  // Token pipe: it advances with the multiplier clock enable. The enable stays high
  // until the last token reaches the final stage, which is then cleared.
  always_comb begin
    mult_en = issue | (|s_q[MULT_LAT-1:1]);
    s_d     = s_q;
    t_d     = t_q;
    if (mult_en) begin
      s_d = {s_q[MULT_LAT-1:1], issue};
      t_d = {t_q[MULT_LAT-1:1], gntId};
    end else begin
      s_d[MULT_LAT] = 1'b0;
    end
  end

  // State registers: the round stage tracks array_mult's free-running rounding register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prio_q  <= 1'b0;
      s_q     <= '0;
      t_q     <= '0;
      r_q     <= 1'b0;
      rt_q    <= 1'b0;
      dataa_q <= '0;
      datab_q <= '0;
    end else begin
      prio_q  <= prio_d;
      s_q     <= s_d;
      t_q     <= t_d;
      r_q     <= s_q[MULT_LAT];
      rt_q    <= t_q[MULT_LAT];
      dataa_q <= dataa_d;
      datab_q <= datab_d;
    end
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign mult_dataa  = dataa_d;
  assign mult_datab  = datab_d;
  assign rsp0_valid  = r_q & ~rt_q;
  assign rsp1_valid  = r_q & rt_q;
  assign rsp0_result = mult_result;
  assign rsp1_result = mult_result;
  assign busy        = (|s_q) | r_q;

endmodule

// File: tb/tb_array_mult_sched.sv
// tb_array_mult_sched: drives both clients with directed and random traffic around a
// behavioural array_mult, and compares every cycle against a transaction-level model.
module tb_array_mult_sched;

  localparam int N = 4;
  localparam int L = 4;
  localparam int W = N * 36;

  typedef struct {
    int          issueCyc;
    logic        id;
    logic [W-1:0] res;
  } Rec;

  logic          clk;
  logic          reset_n;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [W-1:0]  req0_dataa, req0_datab, req1_dataa, req1_datab;
  logic          mult_en;
  logic [W-1:0]  mult_dataa, mult_datab, mult_result;
  logic          rsp0_valid, rsp1_valid;
  logic [W-1:0]  rsp0_result, rsp1_result;
  logic          busy;

  int            checkCount = 0;
  int            failCount  = 0;
  int            cyc        = 0;
  logic          prio       = 1'b0;
  logic          known      = 1'b0;
  logic [W-1:0]  lastA      = '0;
  logic [W-1:0]  lastB      = '0;
  Rec            q[$];

  logic [W-1:0]  pipeA [1:L];
  logic [W-1:0]  pipeB [1:L];
  logic [W-1:0]  va, vb;

  array_mult_sched #(.N(N), .MULT_LAT(L)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_dataa(req0_dataa), .req0_datab(req0_datab),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_dataa(req1_dataa), .req1_datab(req1_datab),
    .mult_en(mult_en), .mult_dataa(mult_dataa), .mult_datab(mult_datab),
    .mult_result(mult_result),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_result(rsp0_result), .rsp1_result(rsp1_result),
    .busy(busy)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Q18 multiply with round half up: bits [53:18] of the full product plus bit 17.
  function automatic logic [35:0] qmul(input logic [35:0] a, input logic [35:0] b);
    logic signed [71:0] pa, pb, p;
    pa = {{36{a[35]}}, a};
    pb = {{36{b[35]}}, b};
    p  = pa * pb;
    return p[53:18] + {35'd0, p[17]};
  endfunction

  function automatic logic [W-1:0] qmulVec(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] res;
    res = '0;
    for (int i = 0; i < N; i++) res[i*36 +: 36] = qmul(a[i*36 +: 36], b[i*36 +: 36]);
    return res;
  endfunction

  function automatic logic [W-1:0] randVec();
    logic [W-1:0] v;
    logic [63:0]  tmp;
    v = '0;
    for (int i = 0; i < N; i++) begin
      tmp = {$urandom(), $urandom()};
      v[i*36 +: 36] = tmp[35:0];
    end
    return v;
  endfunction

  // Behavioural array_mult: clock-enabled multiplier pipeline with unreset stages,
  // followed by a free-running rounding register.
  initial begin
    for (int k = 1; k <= L; k++) begin
      pipeA[k] = '0;
      pipeB[k] = '0;
    end
    mult_result = '0;
  end

  always @(posedge clk) begin
    if (mult_en) begin
      pipeA[1] <= mult_dataa;
      pipeB[1] <= mult_datab;
      for (int k = 2; k <= L; k++) begin
        pipeA[k] <= pipeA[k-1];
        pipeB[k] <= pipeB[k-1];
      end
    end
    mult_result <= qmulVec(pipeA[L], pipeB[L]);
  end

  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // One cycle: drive inputs at the falling edge, compare outputs, then advance the model.
  task automatic applyStimulus(input logic v0, input logic v1,
                               input logic [W-1:0] a0, input logic [W-1:0] b0,
                               input logic [W-1:0] a1, input logic [W-1:0] b1,
                               input logic rstn);
    logic         gnt, gid, expEn, expBusy, expR0, expR1;
    logic [W-1:0] expRes, expA, expB;
    Rec           rec;
    @(negedge clk);
    req0_valid = v0; req1_valid = v1;
    req0_dataa = a0; req0_datab = b0;
    req1_dataa = a1; req1_datab = b1;
    reset_n    = rstn;
    #1;
    gnt = 1'b0;
    gid = 1'b0;
    if (rstn) begin
      if (v0 && v1) begin gnt = 1'b1; gid = prio; end
      else if (v0)  begin gnt = 1'b1; gid = 1'b0; end
      else if (v1)  begin gnt = 1'b1; gid = 1'b1; end
    end
    expEn = gnt; expBusy = 1'b0; expR0 = 1'b0; expR1 = 1'b0; expRes = '0;
    foreach (q[i]) begin
      if (q[i].issueCyc >= cyc - L + 1 && q[i].issueCyc <= cyc - 1) expEn = 1'b1;
      if (q[i].issueCyc >= cyc - L - 1) expBusy = 1'b1;
    end
    if (q.size() > 0 && q[0].issueCyc == cyc - L - 1) begin
      expR0  = !q[0].id;
      expR1  = q[0].id;
      expRes = q[0].res;
    end
    expA = gnt ? (gid ? a1 : a0) : lastA;
    expB = gnt ? (gid ? b1 : b0) : lastB;

    checkOutput("req0_ready", W'(req0_ready), W'(gnt && !gid));
    checkOutput("req1_ready", W'(req1_ready), W'(gnt && gid));
    if (known) begin
      checkOutput("mult_en",    W'(mult_en),    W'(expEn));
      checkOutput("busy",       W'(busy),       W'(expBusy));
      checkOutput("rsp0_valid", W'(rsp0_valid), W'(expR0));
      checkOutput("rsp1_valid", W'(rsp1_valid), W'(expR1));
      checkOutput("mult_dataa", mult_dataa, expA);
      checkOutput("mult_datab", mult_datab, expB);
      if (expR0) checkOutput("rsp0_result", rsp0_result, expRes);
      if (expR1) checkOutput("rsp1_result", rsp1_result, expRes);
    end

    if (expR0 || expR1) void'(q.pop_front());
    if (gnt) begin
      rec.issueCyc = cyc;
      rec.id       = gid;
      rec.res      = qmulVec(expA, expB);
      q.push_back(rec);
      prio  = !gid;
      lastA = expA;
      lastB = expB;
    end
    if (!rstn) begin
      q.delete();
      prio  = 1'b0;
      lastA = '0;
      lastB = '0;
      known = 1'b1;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, '0, '0, '0, 1'b1);
  endtask

  // Directed scenarios, then randomized traffic with occasional resets.
  initial begin
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_dataa = '0; req0_datab = '0; req1_dataa = '0; req1_datab = '0;
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
    idle(6);

    // Single issue of 1.0 * 2.5 on every lane.
    applyStimulus(1'b1, 1'b0, {N{36'h0_0004_0000}}, {N{36'h0_000A_0000}}, '0, '0, 1'b1);
    idle(8);

    // Contention: both clients valid for six cycles.
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, randVec(), randVec(), randVec(), randVec(), 1'b1);
    idle(8);

    // Rounding boundary on lane 0.
    va = randVec(); vb = randVec();
    va[35:0] = 36'h0_0000_0001; vb[35:0] = 36'h0_0002_0000;
    applyStimulus(1'b1, 1'b0, va, vb, '0, '0, 1'b1);
    vb[35:0] = 36'h0_0001_0000;
    applyStimulus(1'b1, 1'b0, va, vb, '0, '0, 1'b1);
    idle(8);

    // Gap: client 1 issues twice, six cycles apart.
    applyStimulus(1'b0, 1'b1, '0, '0, randVec(), randVec(), 1'b1);
    idle(5);
    applyStimulus(1'b0, 1'b1, '0, '0, randVec(), randVec(), 1'b1);
    idle(8);

    // Reset while three vectors are in flight.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, randVec(), randVec(), '0, '0, 1'b1);
    applyStimulus(1'b1, 1'b1, randVec(), randVec(), randVec(), randVec(), 1'b0);
    idle(8);

    // Negative operand: -1.5 * 2.0.
    applyStimulus(1'b1, 1'b0, {N{36'hF_FFFA_0000}}, {N{36'h0_0008_0000}}, '0, '0, 1'b1);
    idle(8);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(3, 0) != 0, $urandom_range(2, 0) != 0,
                    randVec(), randVec(), randVec(), randVec(),
                    $urandom_range(63, 0) != 0);
    end
    idle(10);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/array_mult_sched.md
# array_mult_sched

Two-requester scheduler for the `array_mult` lane array of N 36-bit Q18 multipliers. It arbitrates operand vectors from two clients round-robin and issues at most one vector per cycle. It drives the multiplier clock enable so the array only clocks while work is in flight, and tracks each issued vector through the MULT_LAT-stage multiplier and the 1-stage rounding register. Each rounded result vector returns to the client that issued it. It sits between the compute FSMs and `array_mult`.

## Interface
- `N`, default 4: lanes; must match `array_mult`.
- `MULT_LAT`, default 4: pipeline depth of each `mult_36` in clock-enabled cycles; ≥2.
- `clk` in 1: sole clock.
- `reset_n` in 1: synchronous, active-low reset.
- `req0_valid` in 1: client 0 has an operand vector.
- `req0_ready` out 1: client 0 vector accepted this cycle.
- `req0_dataa`, `req0_datab` in N×36: client 0 operands, Q18 signed.
- `req1_valid`, `req1_ready`, `req1_dataa`, `req1_datab`: same for client 1.
- `mult_en` out 1: to `array_mult` en.
- `mult_dataa`, `mult_datab` out N×36: to `array_mult`.
- `mult_result` in N×36: rounded Q18 result from `array_mult`.
- `rsp0_valid` out 1: one-cycle pulse; `rsp0_result` is valid.
- `rsp1_valid` out 1: same for client 1.
- `rsp0_result`, `rsp1_result` out N×36: both driven from `mult_result`.
- `busy` out 1: any vector in flight.

## Operation
- **Arbitration:** a round-robin pointer `prio` (0/1) decides the winner.
  - If only one client is valid, it wins.
  - If both are valid, client `prio` wins.
  - After every grant, `prio` becomes the non-granted client.
- **Handshake:**
  - `reqX_ready` is combinational and equals grant.
  - An issue is `req0_valid&req0_ready` or `req1_valid&req1_ready`.
  - `ready` never asserts without `valid`; at most one `ready` is high per cycle.
  - No response backpressure: clients must accept `rsp` pulses.
- **Operand mux:** `mult_dataa`/`mult_datab` equal the granted client's operands. When there is no grant they hold their last value.
- **Token pipe:** `s[1..MULT_LAT]` holds valid bits and `t[1..MULT_LAT]` holds the client tag.
  - `mult_en = issue | OR(s[1..MULT_LAT-1])`.
  - When `mult_en` is high: `s[1]<=issue`, `t[1]<=granted id`, and `s[k]<=s[k-1]`, `t[k]<=t[k-1]`.
  - When `mult_en` is low: `s[MULT_LAT]<=0`. All other stages are already 0.
  - `s[MULT_LAT]` means the raw multiplier output for that token is present now.
- **Round stage:** `r<=s[MULT_LAT]` and `rt<=t[MULT_LAT]` every cycle, tracking the free-running rounding register in `array_mult`.
  - `rsp0_valid = r & ~rt`; `rsp1_valid = r & rt`.
- `busy = OR(s) | r`.
- Arithmetic is done entirely in `array_mult`: result = bits [53:18] of the 72-bit product, plus 1 if bit 17 is set (round half up). The scheduler never alters data.
- The mult_36 internal registers are not reset. Stale data is harmless because only token-marked cycles produce `rsp` pulses.

## Timing
- **Reset values:** `prio=0`, `s=0`, `t=0`, `r=0`, `rt=0`. Therefore `mult_en=0`, `rsp*_valid=0`, `busy=0`, and `req*_ready=0` unless `valid`.
- **Outputs on `reset_n=0`:** `ready` outputs are forced to 0. `mult_dataa`/`mult_datab` reset to 0.
- **Latency:** a vector issued in cycle T produces its `rsp` pulse in cycle T+MULT_LAT+1, with `rsp_result` valid in that same cycle.
  - This holds for back-to-back issue and for isolated issue.
  - Throughput is 1 vector per cycle.
- **Ordering:** responses return in issue order.
- **Idle gaps:** while a gap exists, `mult_en` stays high until the last token reaches stage MULT_LAT, then drops. The following cycle the round stage captures the held output.
- **Simultaneous events:**
  - Issue in the same cycle as another token reaches `s[MULT_LAT]`: both proceed, no bubble.
  - Both clients valid: exactly one grant.
- **Reset mid-operation:** all in-flight tokens are discarded and no `rsp` pulse occurs from cycle reset+1 onward. The first issue after reset has full latency.

## Test plan
- **Single issue:** client 0 issues in cycle 10 with all lanes a=36'h0_0004_0000 (1.0), b=36'h0_000A_0000 (2.5), MULT_LAT=4 -> `rsp0_valid` high only in cycle 15 with all lanes 36'h0_000A_0000, `rsp1_valid` never high, and `mult_en` high in cycles 10-13 only.
- **Contention:** both clients continuously valid for 6 cycles after reset -> grants 0,1,0,1,0,1; `rsp` pulses alternate 0,1,... starting 5 cycles after the first grant, with no gaps.
- **Rounding:** lane0 a=36'h0_0000_0001, b=36'h0_0002_0000 (product bit17 set) -> result 36'h0_0000_0001; a=1, b=36'h0_0001_0000 -> result 0.
- **Gap:** client 1 issues in cycles 3 and 9 -> `rsp1_valid` in cycles 8 and 14 with the correct data; `busy` is low in cycles 9.. only between tokens as specified.
- **Reset mid-flight:** issue 3 vectors in cycles 5-7, `reset_n=0` in cycle 8 -> no `rsp` pulses afterwards, `busy=0` and `mult_en=0` from cycle 9.
- **Negative operands:** a=-1.5 (36'hF_FFFA_0000), b=2.0 (36'h0_0008_0000) -> result 36'hF_FFF4_0000 (-3.0).
